// File: rtl/bp_me_wormhole_packet_rx.sv
// bp_me_wormhole_packet_rx
//   Receive endpoint of a coherence-NoC wormhole channel. Accepts flits over a
//   ready/valid link, validates the header (destination cord and body length)
//   and reassembles one packet. The packet is presented to tile logic with a
//   valid/yumi handshake. Misrouted or over-length packets are consumed and
//   dropped, and each such drop is flagged with a one-cycle pulse.
// Ports
//   clk_i, reset_i      clock, synchronous active-high reset
//   my_cord_i           coordinate of this endpoint
//   flit_v_i/flit_i     incoming flit valid and data
//   flit_ready_and_o    endpoint can accept a flit this cycle
//   packet_v_o          assembled packet valid
//   packet_o            packet; flit k is at [k*flit_width_p +: flit_width_p]
//   packet_len_o        body length of the presented packet
//   packet_yumi_i       consumer takes the packet
//   misroute_o          pulse: the header cord did not match, packet dropped
//   overlen_o           pulse: the header length was too large, packet dropped

module bp_me_wormhole_packet_rx #(
    parameter int flit_width_p     = 64,
    parameter int cord_width_p     = 8,
    parameter int len_width_p      = 4,
    parameter int max_body_flits_p = 3
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic [cord_width_p-1:0]                     my_cord_i,
    input  logic                                        flit_v_i,
    input  logic [flit_width_p-1:0]                     flit_i,
    output logic                                        flit_ready_and_o,
    output logic                                        packet_v_o,
    output logic [flit_width_p*(max_body_flits_p+1)-1:0] packet_o,
    output logic [len_width_p-1:0]                      packet_len_o,
    input  logic                                        packet_yumi_i,
    output logic                                        misroute_o,
    output logic                                        overlen_o
);
    localparam int slots_lp = max_body_flits_p + 1;

    typedef enum logic [1:0] {
        e_header = 2'd0,
        e_body   = 2'd1,
        e_drop   = 2'd2,
        e_full   = 2'd3
    } state_e;

    state_e                  r_state;
    state_e                  w_state_n;
    logic [flit_width_p-1:0] r_slots [slots_lp];
    logic [len_width_p-1:0]  r_len;
    logic [len_width_p-1:0]  r_count;
    logic                    r_misroute;
    logic                    r_overlen;

    logic                    w_ready;
    logic                    w_xfer;
    logic [cord_width_p-1:0] w_hdr_cord;
    logic [len_width_p-1:0]  w_hdr_len;
    logic                    w_cord_bad;
    logic                    w_len_bad;
    logic [len_width_p-1:0]  w_count_inc;
    logic                    w_last;
    logic                    w_hdr_xfer;

    // Ready depends on state only, so there is no path from flit_v_i.
    assign w_ready     = (r_state != e_full);
    assign w_xfer      = flit_v_i & w_ready;
    assign w_hdr_cord  = flit_i[cord_width_p-1:0];
    assign w_hdr_len   = flit_i[cord_width_p +: len_width_p];
    assign w_cord_bad  = (w_hdr_cord != my_cord_i);
    assign w_len_bad   = (w_hdr_len > len_width_p'(max_body_flits_p));
    assign w_count_inc = r_count + {{(len_width_p-1){1'b0}}, 1'b1};
    assign w_last      = (w_count_inc == r_len);
    assign w_hdr_xfer  = (r_state == e_header) & w_xfer;

    // Next-state decode.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            e_header: begin
                if (!w_xfer) begin
                    w_state_n = e_header;
                end else if (w_cord_bad) begin
                    // A misrouted header with no body needs no drop phase.
                    w_state_n = (w_hdr_len == '0) ? e_header : e_drop;
                end else if (w_len_bad) begin
                    w_state_n = e_drop;
                end else if (w_hdr_len == '0) begin
                    w_state_n = e_full;
                end else begin
                    w_state_n = e_body;
                end
            end
            e_body: begin
                if (w_xfer && w_last) begin
                    w_state_n = e_full;
                end else begin
                    w_state_n = e_body;
                end
            end
            e_drop: begin
                if (w_xfer && w_last) begin
                    w_state_n = e_header;
                end else begin
                    w_state_n = e_drop;
                end
            end
            e_full: begin
                if (packet_yumi_i) begin
                    w_state_n = e_header;
                end else begin
                    w_state_n = e_full;
                end
            end
            default: w_state_n = e_header;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_header;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Packet buffer, length/count tracking and error pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < slots_lp; k++) begin
                r_slots[k] <= '0;
            end
            r_len      <= '0;
            r_count    <= '0;
            r_misroute <= 1'b0;
            r_overlen  <= 1'b0;
        end else begin
            r_misroute <= w_hdr_xfer & w_cord_bad;
            r_overlen  <= w_hdr_xfer & ~w_cord_bad & w_len_bad;
            case (r_state)
                e_header: begin
                    if (w_xfer) begin
                        // Clearing body slots keeps slots past len at zero.
                        r_slots[0] <= flit_i;
                        for (int k = 1; k < slots_lp; k++) begin
                            r_slots[k] <= '0;
                        end
                        r_len   <= w_hdr_len;
                        r_count <= '0;
                    end
                end
                e_body: begin
                    if (w_xfer) begin
                        for (int k = 1; k < slots_lp; k++) begin
                            if (w_count_inc == len_width_p'(k)) begin
                                r_slots[k] <= flit_i;
                            end
                        end
                        r_count <= w_count_inc;
                    end
                end
                e_drop: begin
                    if (w_xfer) begin
                        r_count <= w_count_inc;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    // Flatten the slot array onto the packet port.
    always_comb begin
        packet_o = '0;
        for (int k = 0; k < slots_lp; k++) begin
            packet_o[k*flit_width_p +: flit_width_p] = r_slots[k];
        end
    end

    assign flit_ready_and_o = w_ready;
    assign packet_v_o       = (r_state == e_full);
    assign packet_len_o     = r_len;
    assign misroute_o       = r_misroute;
    assign overlen_o        = r_overlen;

    bp_me_wormhole_packet_rx_chk u_chk (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .packet_v_i   (packet_v_o),
        .packet_yumi_i(packet_yumi_i),
        .misroute_i   (r_misroute),
        .overlen_i    (r_overlen)
    );
endmodule

// Protocol checks for the receive endpoint.
module bp_me_wormhole_packet_rx_chk (
    input logic clk_i,
    input logic reset_i,
    input logic packet_v_i,
    input logic packet_yumi_i,
    input logic misroute_i,
    input logic overlen_i
);
    a_yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) packet_yumi_i |-> packet_v_i);

    a_errors_exclusive: assert property (
        @(posedge clk_i) disable iff (reset_i) !(misroute_i && overlen_i));
endmodule

// File: tb/tb_bp_me_wormhole_packet_rx.sv
module tb_bp_me_wormhole_packet_rx;
    localparam int FW = 64;
    localparam int PW = 256;
    localparam logic [7:0] MY = 8'h3C;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [7:0]    my_cord_i = MY;
    logic          flit_v_i = 1'b0;
    logic [FW-1:0] flit_i = '0;
    logic          flit_ready_and_o;
    logic          packet_v_o;
    logic [PW-1:0] packet_o;
    logic [3:0]    packet_len_o;
    logic          packet_yumi_i = 1'b0;
    logic          misroute_o;
    logic          overlen_o;

    int total = 0;
    int bad = 0;

    bp_me_wormhole_packet_rx dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .my_cord_i       (my_cord_i),
        .flit_v_i        (flit_v_i),
        .flit_i          (flit_i),
        .flit_ready_and_o(flit_ready_and_o),
        .packet_v_o      (packet_v_o),
        .packet_o        (packet_o),
        .packet_len_o    (packet_len_o),
        .packet_yumi_i   (packet_yumi_i),
        .misroute_o      (misroute_o),
        .overlen_o       (overlen_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          chk;
        logic          rst;
        logic          fv;
        logic [FW-1:0] flit;
        logic          yumi;
        logic          rdy;
        logic          v;
        logic          mis;
        logic          ovl;
        logic [3:0]    len;
        logic [PW-1:0] pkt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [FW-1:0] hdr(logic [7:0] cord, logic [3:0] len, logic [7:0] tag);
        return {tag, 44'h0, len, cord};
    endfunction

    function automatic logic [PW-1:0] pk(logic [FW-1:0] s3, logic [FW-1:0] s2,
                                         logic [FW-1:0] s1, logic [FW-1:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    task automatic add(logic rst, logic fv, logic [FW-1:0] flit, logic yumi,
                       logic rdy, logic v, logic mis, logic ovl, logic [3:0] len,
                       logic [PW-1:0] pkt);
        vec_t t;
        t.chk = 1'b1; t.rst = rst; t.fv = fv; t.flit = flit; t.yumi = yumi;
        t.rdy = rdy; t.v = v; t.mis = mis; t.ovl = ovl; t.len = len; t.pkt = pkt;
        vecs.push_back(t);
    endtask

    task automatic check(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    logic [FW-1:0] h1, h2, h3, hb, h4, h5, h6, h7, h8, hm, h9;
    logic [PW-1:0] p1, p2, p3, pb, p4, p5, p6, p7a, p7b, p8, pm;
    localparam logic [FW-1:0] Z = 64'h0;

    initial begin
        h1 = hdr(MY, 4'd0, 8'hA5);
        h2 = hdr(MY, 4'd3, 8'h02);
        h3 = hdr(MY, 4'd0, 8'h07);
        hb = hdr(MY ^ 8'h01, 4'd2, 8'h0B);
        h4 = hdr(MY, 4'd0, 8'h44);
        h5 = hdr(MY, 4'd5, 8'h55);
        h6 = hdr(MY, 4'd1, 8'h66);
        h7 = hdr(MY, 4'd3, 8'h77);
        h8 = hdr(MY, 4'd0, 8'h88);
        hm = hdr(MY ^ 8'h01, 4'd0, 8'h4D);
        h9 = hdr(MY, 4'd2, 8'h99);
        p1  = pk(Z, Z, Z, h1);
        p2  = pk(64'h33, 64'h22, 64'h11, h2);
        p3  = pk(Z, Z, Z, h3);
        pb  = pk(Z, Z, Z, hb);
        p4  = pk(Z, Z, Z, h4);
        p5  = pk(Z, Z, Z, h5);
        p6  = pk(Z, Z, 64'h61, h6);
        p7a = pk(Z, Z, Z, h7);
        p7b = pk(Z, Z, 64'h71, h7);
        p8  = pk(Z, Z, Z, h8);
        pm  = pk(Z, Z, Z, hm);

        //  rst fv  flit          yumi rdy  v    mis  ovl  len  pkt
        add(1, 0, Z,              0,   1,   0,   0,   0,   0,   '0);
        vecs[0].chk = 1'b0;
        add(1, 1, h3,             0,   1,   0,   0,   0,   0,   '0);
        // 1: len=0 packet
        add(0, 1, h1,             0,   1,   0,   0,   0,   0,   '0);
        add(0, 0, Z,              0,   0,   1,   0,   0,   0,   p1);
        add(0, 0, Z,              1,   0,   1,   0,   0,   0,   p1);
        // 2: len=3 with gapped body flits
        add(0, 1, h2,             0,   1,   0,   0,   0,   0,   p1);
        add(0, 0, Z,              0,   1,   0,   0,   0,   3,   pk(Z, Z, Z, h2));
        add(0, 1, 64'h11,         0,   1,   0,   0,   0,   3,   pk(Z, Z, Z, h2));
        add(0, 0, Z,              0,   1,   0,   0,   0,   3,   pk(Z, Z, 64'h11, h2));
        add(0, 1, 64'h22,         0,   1,   0,   0,   0,   3,   pk(Z, Z, 64'h11, h2));
        add(0, 0, Z,              0,   1,   0,   0,   0,   3,   pk(Z, 64'h22, 64'h11, h2));
        add(0, 1, 64'h33,         0,   1,   0,   0,   0,   3,   pk(Z, 64'h22, 64'h11, h2));
        // 3: consumer stalls 5 cycles with the next header offered
        for (int i = 0; i < 5; i++) add(0, 1, h3, 0, 0, 1, 0, 0, 3, p2);
        add(0, 1, h3,             1,   0,   1,   0,   0,   3,   p2);
        add(0, 1, h3,             0,   1,   0,   0,   0,   3,   p2);
        add(0, 0, Z,              1,   0,   1,   0,   0,   0,   p3);
        // 4: misrouted len=2, then a good len=0 packet
        add(0, 1, hb,             0,   1,   0,   0,   0,   0,   p3);
        add(0, 1, 64'hDEAD,       0,   1,   0,   1,   0,   2,   pb);
        add(0, 1, 64'hBEEF,       0,   1,   0,   0,   0,   2,   pb);
        add(0, 1, h4,             0,   1,   0,   0,   0,   2,   pb);
        add(0, 0, Z,              1,   0,   1,   0,   0,   0,   p4);
        // 5: over-length header, 5 body flits dropped, then len=1 packet
        add(0, 1, h5,             0,   1,   0,   0,   0,   0,   p4);
        add(0, 1, 64'h51,         0,   1,   0,   0,   1,   5,   p5);
        for (int i = 2; i <= 5; i++) add(0, 1, 64'h50 + i, 0, 1, 0, 0, 0, 5, p5);
        add(0, 1, h6,             0,   1,   0,   0,   0,   5,   p5);
        add(0, 1, 64'h61,         0,   1,   0,   0,   0,   1,   pk(Z, Z, Z, h6));
        add(0, 0, Z,              1,   0,   1,   0,   0,   1,   p6);
        // 6: reset after the first of three body flits
        add(0, 1, h7,             0,   1,   0,   0,   0,   1,   p6);
        add(0, 1, 64'h71,         0,   1,   0,   0,   0,   3,   p7a);
        add(1, 1, 64'h72,         0,   1,   0,   0,   0,   3,   p7b);
        add(1, 0, Z,              0,   1,   0,   0,   0,   0,   '0);
        add(0, 1, h8,             0,   1,   0,   0,   0,   0,   '0);
        add(0, 0, Z,              1,   0,   1,   0,   0,   0,   p8);
        // misrouted header with len=0 needs no drop phase
        add(0, 1, hm,             0,   1,   0,   0,   0,   0,   p8);
        add(0, 0, Z,              0,   1,   0,   1,   0,   0,   pm);
        add(0, 0, Z,              0,   1,   0,   0,   0,   0,   pm);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset_i       = vecs[i].rst;
            flit_v_i      = vecs[i].fv;
            flit_i        = vecs[i].flit;
            packet_yumi_i = vecs[i].yumi;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d.ready", i), PW'(flit_ready_and_o), PW'(vecs[i].rdy));
                check($sformatf("v%0d.valid", i), PW'(packet_v_o), PW'(vecs[i].v));
                check($sformatf("v%0d.misroute", i), PW'(misroute_o), PW'(vecs[i].mis));
                check($sformatf("v%0d.overlen", i), PW'(overlen_o), PW'(vecs[i].ovl));
                check($sformatf("v%0d.len", i), PW'(packet_len_o), PW'(vecs[i].len));
                check($sformatf("v%0d.packet", i), packet_o, vecs[i].pkt);
            end
        end

        // Hand-written: len=2 packet delivered back to back, wait bounded.
        begin
            logic [FW-1:0] seq [3];
            int waited;
            seq[0] = h9; seq[1] = 64'h91; seq[2] = 64'h92;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                flit_v_i = 1'b1; flit_i = seq[k]; packet_yumi_i = 1'b0;
                #1;
                check($sformatf("seq.ready%0d", k), PW'(flit_ready_and_o), PW'(1'b1));
            end
            @(negedge clk);
            flit_v_i = 1'b0;
            waited = 0;
            while (!packet_v_o && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("seq.latency", PW'(waited), PW'(0));
            check("seq.packet", packet_o, pk(Z, 64'h92, 64'h91, h9));
            check("seq.len", PW'(packet_len_o), PW'(4'd2));
            packet_yumi_i = 1'b1;
            @(negedge clk);
            packet_yumi_i = 1'b0;
            #1;
            check("seq.released", PW'(packet_v_o), PW'(1'b0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
